johnson_seq_gen: RTL
====================

# johnson_seq_gen

Parametrised Johnson/ring sequence generator: the successor to the fixed-width Johnson counter tile. It adds selectable width, Johnson or ring mode, direction control, a programmable step prescaler, parallel load, a phase index and a wrap pulse. An optional illegal-state self-correction feature can be compiled in. It sits directly behind the tile I/O and drives the output pins or downstream phase-select logic.

## Interface
Parameters:
- `WIDTH`, default 8: sequence register width, must be ≥ 2.
- `DIV_W`, default 8: prescaler divisor width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `ena`, in, 1: global enable. While low, all state holds.
- `mode`, in, 2: `00` Johnson, `01` ring, `10` hold, `11` load.
- `dir`, in, 1: `0` shift toward MSB (phase counts up); `1` shift toward LSB (phase counts down).
- `div`, in, DIV_W: one step every `div+1` enabled run cycles.
- `load_val`, in, WIDTH: parallel load value.
- `q`, out, WIDTH: sequence register.
- `phase`, out, `$clog2(2*WIDTH)`: phase index relative to the last reset or load.
- `wrap`, out, 1: one-cycle registered pulse marking sequence wrap.
- `state_ok`, out, 1: combinational legality flag for `q`.

## Operation
- Reset (async, `rst_n`=0): `q`=0, `phase`=0, `wrap`=0, prescaler count `pc`=0.
- `ena`=0: `q`, `phase`, `pc` hold; `wrap` clears.
- Run modes (`00`, `01`), gated by `ena`=1:
  - If `pc >= div`: `pc` ← 0 and the cycle is a step. Otherwise `pc` ← `pc+1`.
  - The `>=` compare means lowering `div` mid-count produces a step on the next cycle, never a long wrap.
- Johnson step:
  - `dir`=0: `q` ← {q[W-2:0], ~q[W-1]}.
  - `dir`=1: `q` ← {~q[0], q[W-1:1]}.
  - `phase` moves ±1 modulo 2·WIDTH.
- Ring step:
  - `dir`=0: `q` ← {q[W-2:0], q[W-1]}.
  - `dir`=1: `q` ← {q[0], q[W-1:1]}.
  - `phase` moves ±1 modulo WIDTH.
- Hold (`10`): `q`, `phase`, `pc` hold.
- Load (`11`, with `ena`=1): `q` ← `load_val`, `phase` ← 0, `pc` ← 0, independent of the prescaler.
- Switching between mode `00` and `01`: `phase` ← 0 and `pc` ← 0 on the first cycle in the new mode. No step occurs that cycle. `q` is unchanged.
- `wrap`: set on the edge after a step whose next `phase` is 0; cleared otherwise. Load, reset and correction never raise `wrap`.
- `state_ok`:
  - Johnson mode: high when the circular bit-transition count of `q` is ≤ 2 (thermometer patterns).
  - Ring mode: high when `q` is one-hot.
  - Hold and load: high.

## Timing
- `q`/`phase` update on the step edge, with no further latency.
- After reset or load, the first step occurs on the (`div`+1)-th enabled run cycle.
- `wrap` is high exactly one cycle, during the cycle after the wrapping edge.
- Simultaneous load and step: load wins.
- Reset mid-operation clears everything immediately; the first step after release follows the `div`+1 rule.

## Configuration
- `JOHNSON_SELFCORRECT_EN` defined:
  - Johnson step with `state_ok`=0: `q` ← 0, `phase` ← 0.
  - Ring step with `state_ok`=0 (including `q`=0): `q` ← 1 (LSB only), `phase` ← 0.
  - No `wrap` on a corrected step.
- Not defined:
  - Steps always apply the plain shift; illegal patterns circulate.
  - Ring mode from `q`=0 stays 0.
  - `state_ok` is still computed.

## Test plan
- WIDTH=4, `div`=0, mode `00`, `dir`=0, from reset -> `q` = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; `phase` 0→7→0; `wrap`=1 for one cycle after the 8th step.
- Same setup with `dir`=1 -> `q` = 1000, 1100, 1110, 1111, 0111, …; `phase` = 7, 6, …; `wrap` after the 8th step.
- `div`=2 -> `q` changes every 3rd cycle. Drop `ena` for 5 cycles mid-count -> `q`, `pc`, `phase` frozen; the step resumes at the remaining count.
- Load 0101, then mode `00`, `dir`=0, `div`=0 -> `state_ok`=0. With macro: `q`=0000, `phase`=0, no `wrap`. Without macro: `q`=1011.
- Ring mode from reset, with macro -> `q` = 0001 (corrected), 0010, 0100, 1000, 0001; `wrap` after the 4th post-correction step.
- Assert `rst_n` low between edges while `q`=0111 -> `q`=0 and `phase`=0 without a clock edge; `wrap`=0.

Source files
------------

// File: rtl/johnson_seq_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | johnson_seq_gen: parametrised Johnson/ring sequence generator with       |
// | prescaler, parallel load, phase index and wrap pulse.                    |
// | Optional macro JOHNSON_SELFCORRECT_EN: illegal-state self-correction.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module johnson_seq_gen #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [1:0]                    mode,
  input  logic                          dir,
  input  logic [DIV_W-1:0]              div,
  input  logic [WIDTH-1:0]              load_val,
  output logic [WIDTH-1:0]              q,
  output logic [$clog2(2*WIDTH)-1:0]    phase,
  output logic                          wrap,
  output logic                          state_ok
);

  localparam int PHASE_W = $clog2(2*WIDTH);
  localparam int CNT_W   = $clog2(WIDTH+1) + 1;

  localparam logic [1:0] MODE_JOHNSON = 2'b00;
  localparam logic [1:0] MODE_RING    = 2'b01;
  localparam logic [1:0] MODE_LOAD    = 2'b11;

  localparam logic [PHASE_W-1:0] JOHNSON_LAST = PHASE_W'(2*WIDTH-1);
  localparam logic [PHASE_W-1:0] RING_LAST    = PHASE_W'(WIDTH-1);

  logic [WIDTH-1:0]   q_q, q_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0]   pc_q, pc_d;
  logic               wrap_q, wrap_d;
  // seen_q: a run mode has been used since reset/load; last_ring_q: which one
  logic               seen_q, seen_d;
  logic               last_ring_q, last_ring_d;

  logic [WIDTH-1:0]   rot;
  logic [CNT_W-1:0]   trans_cnt;
  logic [CNT_W-1:0]   ones_cnt;
  logic [WIDTH-1:0]   shift_val;
  logic [PHASE_W-1:0] ph_last;
  logic [PHASE_W-1:0] ph_next;
  logic               correct;

  always_comb begin
    rot       = {q_q[0], q_q[WIDTH-1:1]};
    trans_cnt = '0;
    ones_cnt  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      trans_cnt = trans_cnt + CNT_W'(q_q[i] ^ rot[i]);
      ones_cnt  = ones_cnt + CNT_W'(q_q[i]);
    end
    case (mode)
      MODE_JOHNSON: state_ok = (trans_cnt <= CNT_W'(2));
      MODE_RING:    state_ok = (ones_cnt == CNT_W'(1));
      default:      state_ok = 1'b1;
    endcase
  end

  always_comb begin
    case ({mode[0], dir})
      2'b00:   shift_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
      2'b01:   shift_val = {~q_q[0], q_q[WIDTH-1:1]};
      2'b10:   shift_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      default: shift_val = {q_q[0], q_q[WIDTH-1:1]};
    endcase
    ph_last = mode[0] ? RING_LAST : JOHNSON_LAST;
    if (!dir) begin
      ph_next = (phase_q >= ph_last) ? '0 : phase_q + PHASE_W'(1);
    end else begin
      ph_next = (phase_q == '0) ? ph_last : phase_q - PHASE_W'(1);
    end
`ifdef JOHNSON_SELFCORRECT_EN
    correct = ~state_ok;
`else
    correct = 1'b0;
`endif
  end

  always_comb begin
    q_d         = q_q;
    phase_d     = phase_q;
    pc_d        = pc_q;
    wrap_d      = 1'b0;
    seen_d      = seen_q;
    last_ring_d = last_ring_q;
    if (ena) begin
      case (mode)
        MODE_LOAD: begin
          q_d     = load_val;
          phase_d = '0;
          pc_d    = '0;
          seen_d  = 1'b0;
        end
        MODE_JOHNSON, MODE_RING: begin
          seen_d      = 1'b1;
          last_ring_d = mode[0];
          // Johnson<->ring change: restart phase and prescaler, no step
          if (seen_q && (last_ring_q != mode[0])) begin
            phase_d = '0;
            pc_d    = '0;
          end else if (pc_q >= div) begin
            pc_d = '0;
            if (correct) begin
              q_d     = mode[0] ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
              phase_d = '0;
            end else begin
              q_d     = shift_val;
              phase_d = ph_next;
              wrap_d  = (ph_next == '0);
            end
          end else begin
            pc_d = pc_q + DIV_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      phase_q     <= '0;
      pc_q        <= '0;
      wrap_q      <= 1'b0;
      seen_q      <= 1'b0;
      last_ring_q <= 1'b0;
    end else begin
      q_q         <= q_d;
      phase_q     <= phase_d;
      pc_q        <= pc_d;
      wrap_q      <= wrap_d;
      seen_q      <= seen_d;
      last_ring_q <= last_ring_d;
    end
  end

  assign q     = q_q;
  assign phase = phase_q;
  assign wrap  = wrap_q;

endmodule
`default_nettype wire
